// File: rtl/adbg_tap_pkg.sv
// -----------------------------------------------------------------------------
// adbg_tap_pkg
// Shared definitions for the JTAG TAP controller of the advanced debug
// interface: the 16 TAP FSM states, the instruction opcodes and the default
// instruction register length.
// No ports (package).
// -----------------------------------------------------------------------------
package adbg_tap_pkg;

    localparam int TAP_IR_LEN = 4;

    typedef enum logic [3:0] {
        TAP_TLR        = 4'd0,
        TAP_RTI        = 4'd1,
        TAP_SELECT_DR  = 4'd2,
        TAP_CAPTURE_DR = 4'd3,
        TAP_SHIFT_DR   = 4'd4,
        TAP_EXIT1_DR   = 4'd5,
        TAP_PAUSE_DR   = 4'd6,
        TAP_EXIT2_DR   = 4'd7,
        TAP_UPDATE_DR  = 4'd8,
        TAP_SELECT_IR  = 4'd9,
        TAP_CAPTURE_IR = 4'd10,
        TAP_SHIFT_IR   = 4'd11,
        TAP_EXIT1_IR   = 4'd12,
        TAP_PAUSE_IR   = 4'd13,
        TAP_EXIT2_IR   = 4'd14,
        TAP_UPDATE_IR  = 4'd15
    } tap_state_t;

    localparam logic [3:0] TAP_EXTEST         = 4'b0000;
    localparam logic [3:0] TAP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] TAP_IDCODE         = 4'b0010;
    localparam logic [3:0] TAP_DEBUG          = 4'b1000;
    localparam logic [3:0] TAP_MBIST          = 4'b1001;
    localparam logic [3:0] TAP_BYPASS         = 4'b1111;

endpackage

// File: rtl/adbg_tap_fsm.sv
// -----------------------------------------------------------------------------
// adbg_tap_fsm
// IEEE 1149.1 TAP state machine: state register, next-state logic and the
// state decodes used by the TAP registers and the debug top.
// Ports:
//   i_tck, i_rst        JTAG clock (rising edge), TRST (async, active-high)
//   i_tms               test mode select
//   o_tlr               TEST_LOGIC_RESET
//   o_capture_dr/o_shift_dr/o_pause_dr/o_update_dr   DR-side state decodes
//   o_capture_ir/o_shift_ir/o_update_ir              IR-side state decodes
// -----------------------------------------------------------------------------
module adbg_tap_fsm
    import adbg_tap_pkg::*;
(
    input  logic i_tck,
    input  logic i_rst,
    input  logic i_tms,
    output logic o_tlr,
    output logic o_capture_dr,
    output logic o_shift_dr,
    output logic o_pause_dr,
    output logic o_update_dr,
    output logic o_capture_ir,
    output logic o_shift_ir,
    output logic o_update_ir
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_ff @(posedge i_tck or posedge i_rst) begin
        if (i_rst) r_state <= TAP_TLR;
        else       r_state <= w_next;
    end

    // Decodes depend on r_state only, so they are stable for a whole TCK period.
    always_comb begin
        w_next       = r_state;
        o_tlr        = 1'b0;
        o_capture_dr = 1'b0;
        o_shift_dr   = 1'b0;
        o_pause_dr   = 1'b0;
        o_update_dr  = 1'b0;
        o_capture_ir = 1'b0;
        o_shift_ir   = 1'b0;
        o_update_ir  = 1'b0;
        unique case (r_state)
            TAP_TLR: begin
                o_tlr  = 1'b1;
                w_next = i_tms ? TAP_TLR : TAP_RTI;
            end
            TAP_RTI:        w_next = i_tms ? TAP_SELECT_DR : TAP_RTI;
            TAP_SELECT_DR:  w_next = i_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: begin
                o_capture_dr = 1'b1;
                w_next       = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            end
            TAP_SHIFT_DR: begin
                o_shift_dr = 1'b1;
                w_next     = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            end
            TAP_EXIT1_DR:   w_next = i_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: begin
                o_pause_dr = 1'b1;
                w_next     = i_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            end
            TAP_EXIT2_DR:   w_next = i_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: begin
                o_update_dr = 1'b1;
                w_next      = i_tms ? TAP_SELECT_DR : TAP_RTI;
            end
            TAP_SELECT_IR:  w_next = i_tms ? TAP_TLR : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: begin
                o_capture_ir = 1'b1;
                w_next       = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            end
            TAP_SHIFT_IR: begin
                o_shift_ir = 1'b1;
                w_next     = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            end
            TAP_EXIT1_IR:   w_next = i_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   w_next = i_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   w_next = i_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: begin
                o_update_ir = 1'b1;
                w_next      = i_tms ? TAP_SELECT_DR : TAP_RTI;
            end
        endcase
    end

endmodule

// File: rtl/adbg_tap.sv
// -----------------------------------------------------------------------------
// adbg_tap
// JTAG TAP controller for the advanced debug interface. Holds the instruction
// register, the local IDCODE and BYPASS data registers, decodes the latched
// instruction into chain selects and muxes the serial TDO.
// Ports:
//   tck_i, rst_i       JTAG clock, TRST (async, active-high)
//   tms_i, tdi_i       test mode select, test data in
//   tdo_o, tdo_oe_o    test data out and its enable (falling-edge registered)
//   tlr_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o  state strobes
//   debug_select_o, extest_select_o, sample_preload_select_o, mbist_select_o
//                      latched-instruction decodes
//   debug_tdo_i, bs_chain_tdo_i, mbist_tdo_i   serial outputs of external chains
// -----------------------------------------------------------------------------
module adbg_tap
    import adbg_tap_pkg::*;
#(
    parameter int          IR_LEN       = TAP_IR_LEN,
    parameter logic [31:0] IDCODE_VALUE = 32'h149511c3
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic tlr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o,
    output logic extest_select_o,
    output logic sample_preload_select_o,
    output logic mbist_select_o,
    input  logic debug_tdo_i,
    input  logic bs_chain_tdo_i,
    input  logic mbist_tdo_i
);

    localparam logic [IR_LEN-1:0] IR_EXTEST  = IR_LEN'(TAP_EXTEST);
    localparam logic [IR_LEN-1:0] IR_SAMPLE  = IR_LEN'(TAP_SAMPLE_PRELOAD);
    localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(TAP_IDCODE);
    localparam logic [IR_LEN-1:0] IR_DEBUG   = IR_LEN'(TAP_DEBUG);
    localparam logic [IR_LEN-1:0] IR_MBIST   = IR_LEN'(TAP_MBIST);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

    logic              w_capture_ir;
    logic              w_shift_ir;
    logic              w_update_ir;
    logic              w_idcode_select;
    logic              w_tdo_mux;
    logic              w_shifting;

    logic [IR_LEN-1:0] r_ir_shift;
    logic [IR_LEN-1:0] r_ir_latched;
    logic [31:0]       r_idcode;
    logic              r_bypass;
    logic              r_tdo;
    logic              r_tdo_oe;

    adbg_tap_fsm u_fsm (
        .i_tck        (tck_i),
        .i_rst        (rst_i),
        .i_tms        (tms_i),
        .o_tlr        (tlr_o),
        .o_capture_dr (capture_dr_o),
        .o_shift_dr   (shift_dr_o),
        .o_pause_dr   (pause_dr_o),
        .o_update_dr  (update_dr_o),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir)
    );

    // IR shift register: capture pattern ends in 01 so a board-level scan can
    // locate IR boundaries.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)             r_ir_shift <= '0;
        else if (w_capture_ir) r_ir_shift <= IR_CAPTURE;
        else if (w_shift_ir)   r_ir_shift <= {tdi_i, r_ir_shift[IR_LEN-1:1]};
    end

    // Latched IR returns to IDCODE whenever the TAP sits in TEST_LOGIC_RESET.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)            r_ir_latched <= IR_IDCODE;
        else if (tlr_o)       r_ir_latched <= IR_IDCODE;
        else if (w_update_ir) r_ir_latched <= r_ir_shift;
    end

    assign w_idcode_select         = (r_ir_latched == IR_IDCODE);
    assign debug_select_o          = (r_ir_latched == IR_DEBUG);
    assign extest_select_o         = (r_ir_latched == IR_EXTEST);
    assign sample_preload_select_o = (r_ir_latched == IR_SAMPLE);
    assign mbist_select_o          = (r_ir_latched == IR_MBIST);

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)                                  r_idcode <= IDCODE_VALUE;
        else if (capture_dr_o && w_idcode_select)   r_idcode <= IDCODE_VALUE;
        else if (shift_dr_o)                        r_idcode <= {tdi_i, r_idcode[31:1]};
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i)             r_bypass <= 1'b0;
        else if (capture_dr_o) r_bypass <= 1'b0;
        else if (shift_dr_o)   r_bypass <= tdi_i;
    end

    // Unlisted opcodes fall through to the bypass bit.
    always_comb begin
        w_tdo_mux = 1'b0;
        if (w_shift_ir) begin
            w_tdo_mux = r_ir_shift[0];
        end else if (shift_dr_o) begin
            if (w_idcode_select)                              w_tdo_mux = r_idcode[0];
            else if (debug_select_o)                          w_tdo_mux = debug_tdo_i;
            else if (extest_select_o || sample_preload_select_o) w_tdo_mux = bs_chain_tdo_i;
            else if (mbist_select_o)                          w_tdo_mux = mbist_tdo_i;
            else                                              w_tdo_mux = r_bypass;
        end
    end

    assign w_shifting = w_shift_ir | shift_dr_o;

    // Falling-edge launch gives the receiver half a period of setup to the
    // next rising edge.
    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_shifting ? w_tdo_mux : 1'b0;
            r_tdo_oe <= w_shifting;
        end
    end

    assign tdo_o    = r_tdo;
    assign tdo_oe_o = r_tdo_oe;

endmodule
